fbosc_rr_sched: RTL

- Round-robin scheduler that shares one resource (e.g. a feedback-oscillator/toggle datapath) among N requesters.
- Priority is kept as a one-hot rotating token register, like a ring of cross-loaded flops. One bit resets to 1 (preset); all other bits reset to 0.
- Grants the resource to one requester at a time. A hold ends on a done pulse, on request withdrawal, or by forced release after MAX_HOLD cycles.
- Sits between the requesting control FSMs and the shared datapath enable/select.

---
 rtl/fbosc_pkg.sv | 10 +
 rtl/rr_pick.sv | 32 +++
 rtl/fbosc_rr_sched.sv | 94 +++++++++
 3 files changed

// File: rtl/fbosc_pkg.sv
// fbosc_pkg: shared FSM state encoding and token reset value for the round-robin scheduler
package fbosc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
  // Ring preset: only bit 0 of the token comes out of reset set.
  localparam logic [31:0] TOKEN_RST = 32'd1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority pick of the first request at or above the token, wrapping
//   req       : request vector
//   token     : one-hot priority start position
//   winner    : one-hot winner (zero when req is zero)
//   winner_id : binary index of winner
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   token,
  output logic [N-1:0]   winner,
  output logic [IDW-1:0] winner_id
);
  logic armed;
  logic found;
  // Walk the ring twice: arm at the token bit, then take the first request seen.
  always_comb begin
    winner    = '0;
    winner_id = '0;
    armed     = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      armed = armed | token[k % N];
      if (armed && !found && req[k % N]) begin
        found          = 1'b1;
        winner[k % N]  = 1'b1;
        winner_id      = IDW'(k % N);
      end
    end
  end
endmodule

// File: rtl/fbosc_rr_sched.sv
// fbosc_rr_sched: round-robin scheduler granting one shared datapath to one of N requesters
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   req      : level request per requester
//   done     : completion pulse from the granted requester
//   grant    : registered one-hot grant
//   grant_id : registered index of current/last grantee
//   busy     : high while a grant is held
//   timeout  : one-cycle pulse after a forced release
module fbosc_rr_sched
  import fbosc_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t         state_q;
  logic [N-1:0]   token_q;
  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic [HW-1:0]  hold_q;
  logic           busy_q;
  logic           timeout_q;
  logic [N-1:0]   winner;
  logic [IDW-1:0] winner_id;
  logic           rel_done;
  logic           rel_req;
  logic           rel_max;
  logic [N-1:0]   token_d;
  logic [HW-1:0]  hold_d;
  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req      (req),
    .token    (token_q),
    .winner   (winner),
    .winner_id(winner_id)
  );
  assign rel_done = done[grant_id_q];
  assign rel_req  = !req[grant_id_q];
  assign rel_max  = hold_q == HW'(MAX_HOLD);
  // grant_q is one-hot of grant_id, so rotating it left gives one-hot(grant_id+1 mod N).
  assign token_d  = {grant_q[N-2:0], grant_q[N-1]};
  assign hold_d   = rel_max ? hold_q : hold_q + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      token_q    <= N'(TOKEN_RST);
      grant_q    <= '0;
      grant_id_q <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (|req) begin
          grant_q    <= winner;
          grant_id_q <= winner_id;
          hold_q     <= HW'(1);
          busy_q     <= 1'b1;
          state_q    <= ST_BUSY;
        end
        ST_BUSY: begin
          hold_q <= hold_d;
          if (rel_done || rel_req || rel_max) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            token_q   <= token_d;
            // A normal release wins over a coincident hold limit.
            timeout_q <= !rel_done && !rel_req;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          timeout_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;
endmodule
